// File: rtl/systolic_pkg.sv
// Shared constants and state encoding for the systolic-array result drain.
package systolic_pkg;

    localparam int SIZE    = 4;
    localparam int WIDTH   = 8;
    localparam int LATENCY = 3 * SIZE - 2;
    localparam int IDX_W   = 4;
    localparam int CNT_W   = 16;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_WAIT   = 2'd1,
        S_STREAM = 2'd2,
        S_DONE   = 2'd3
    } drain_state_t;

endpackage

// File: rtl/systolic_drain.sv
// Waits for the array to settle, snapshots all SIZE x SIZE results, then
// streams them row-major over a valid/ready port and pulses done.
module systolic_drain #(
    parameter int SIZE    = systolic_pkg::SIZE,
    parameter int WIDTH   = systolic_pkg::WIDTH,
    parameter int LATENCY = systolic_pkg::LATENCY
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] y0,
    input  logic [WIDTH-1:0] y1,
    input  logic [WIDTH-1:0] y2,
    input  logic [WIDTH-1:0] y3,
    input  logic [WIDTH-1:0] y4,
    input  logic [WIDTH-1:0] y5,
    input  logic [WIDTH-1:0] y6,
    input  logic [WIDTH-1:0] y7,
    input  logic [WIDTH-1:0] y8,
    input  logic [WIDTH-1:0] y9,
    input  logic [WIDTH-1:0] y10,
    input  logic [WIDTH-1:0] y11,
    input  logic [WIDTH-1:0] y12,
    input  logic [WIDTH-1:0] y13,
    input  logic [WIDTH-1:0] y14,
    input  logic [WIDTH-1:0] y15,
    output logic [WIDTH-1:0] out_data,
    output logic [3:0]       out_idx,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_last,
    output logic             busy,
    output logic             done
);
    import systolic_pkg::*;

    localparam int               NUM_ELEMS = SIZE * SIZE;
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_ELEMS - 1);
    localparam logic [CNT_W-1:0] WAIT_LOAD = CNT_W'(LATENCY - 1);

    drain_state_t     state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [WIDTH-1:0] snap_q [NUM_ELEMS];
    logic [WIDTH-1:0] y_s    [NUM_ELEMS];
    logic [WIDTH-1:0] out_data_q;
    logic [IDX_W-1:0] out_idx_q;
    logic [IDX_W-1:0] out_idx_d;
    logic             out_valid_q;
    logic             out_last_q;
    logic             busy_q;
    logic             done_q;

    assign y_s[0]  = y0;
    assign y_s[1]  = y1;
    assign y_s[2]  = y2;
    assign y_s[3]  = y3;
    assign y_s[4]  = y4;
    assign y_s[5]  = y5;
    assign y_s[6]  = y6;
    assign y_s[7]  = y7;
    assign y_s[8]  = y8;
    assign y_s[9]  = y9;
    assign y_s[10] = y10;
    assign y_s[11] = y11;
    assign y_s[12] = y12;
    assign y_s[13] = y13;
    assign y_s[14] = y14;
    assign y_s[15] = y15;

    assign out_idx_d = out_idx_q + 4'd1;

    // Drain FSM; every output is a register so downstream sees clean timing.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            out_data_q  <= '0;
            out_idx_q   <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            for (int i = 0; i < NUM_ELEMS; i++) begin
                snap_q[i] <= '0;
            end
        end else begin
            case (state_q)
                S_IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        state_q <= S_WAIT;
                        cnt_q   <= WAIT_LOAD;
                        busy_q  <= 1'b1;
                    end
                end
                S_WAIT: begin
                    if (cnt_q == '0) begin
                        // The first beat is taken straight from the inputs
                        // because the snapshot is written on this same edge.
                        for (int i = 0; i < NUM_ELEMS; i++) begin
                            snap_q[i] <= y_s[i];
                        end
                        state_q     <= S_STREAM;
                        out_idx_q   <= '0;
                        out_data_q  <= y_s[0];
                        out_valid_q <= 1'b1;
                        out_last_q  <= (LAST_IDX == '0);
                    end else begin
                        cnt_q <= cnt_q - 16'd1;
                    end
                end
                S_STREAM: begin
                    if (out_ready) begin
                        if (out_idx_q == LAST_IDX) begin
                            state_q     <= S_DONE;
                            out_data_q  <= '0;
                            out_idx_q   <= '0;
                            out_valid_q <= 1'b0;
                            out_last_q  <= 1'b0;
                            done_q      <= 1'b1;
                        end else begin
                            out_idx_q  <= out_idx_d;
                            out_data_q <= snap_q[out_idx_d];
                            out_last_q <= (out_idx_d == LAST_IDX);
                        end
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q     <= S_IDLE;
                    out_valid_q <= 1'b0;
                    out_last_q  <= 1'b0;
                    busy_q      <= 1'b0;
                    done_q      <= 1'b0;
                end
            endcase
        end
    end

    assign out_data  = out_data_q;
    assign out_idx   = out_idx_q;
    assign out_valid = out_valid_q;
    assign out_last  = out_last_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule

// File: tb/tb_systolic_drain.sv
// Directed bench for systolic_drain: latency, streaming, back-pressure,
// snapshot isolation, ignored restarts and reset mid-transfer.
module tb_systolic_drain;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic       out_ready;
    logic [7:0] y [16];
    logic [7:0] out_data;
    logic [3:0] out_idx;
    logic       out_valid;
    logic       out_last;
    logic       busy;
    logic       done;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    systolic_drain dut (
        .clk(clk), .reset(reset), .start(start),
        .y0(y[0]),   .y1(y[1]),   .y2(y[2]),   .y3(y[3]),
        .y4(y[4]),   .y5(y[5]),   .y6(y[6]),   .y7(y[7]),
        .y8(y[8]),   .y9(y[9]),   .y10(y[10]), .y11(y[11]),
        .y12(y[12]), .y13(y[13]), .y14(y[14]), .y15(y[15]),
        .out_data(out_data), .out_idx(out_idx), .out_valid(out_valid),
        .out_ready(out_ready), .out_last(out_last), .busy(busy), .done(done)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic set_y_ramp;
        for (int k = 0; k < 16; k++) y[k] = 8'(k + 1);
    endtask

    // Pulses start and counts edges until out_valid rises (bounded).
    task automatic launch(output int edges);
        start = 1'b1;
        tick();
        start = 1'b0;
        edges = 1;
        while (!out_valid && edges < 60) begin
            tick();
            edges++;
        end
    endtask

    task automatic test_reset;
        reset = 1'b1; start = 1'b1; out_ready = 1'b1;
        tick(); tick();
        reset = 1'b0; start = 1'b0;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", out_valid); end
        total++; if (out_last !== 1'b0) begin bad++; $display("FAIL reset_last: got %b want 0", out_last); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done: got %b want 0", done); end
        total++; if (out_data !== 8'd0 || out_idx !== 4'd0) begin bad++; $display("FAIL reset_data_idx: got %0d/%0d want 0/0", out_data, out_idx); end
        tick();
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_start_ignored: busy=%b want 0", busy); end
    endtask

    task automatic test_basic;
        int edges;
        set_y_ramp(); out_ready = 1'b1;
        launch(edges);
        total++; if (edges !== 11) begin bad++; $display("FAIL basic_latency: got %0d want 11", edges); end
        for (int i = 0; i < 16; i++) begin
            total++;
            if (out_valid !== 1'b1 || out_idx !== 4'(i) || out_data !== 8'(i + 1) || out_last !== (i == 15) || busy !== 1'b1) begin
                bad++;
                $display("FAIL basic_beat%0d: valid=%b idx=%0d data=%0d last=%b busy=%b want idx=%0d data=%0d", i, out_valid, out_idx, out_data, out_last, busy, i, i + 1);
            end
            tick();
        end
        total++; if (done !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b1 || out_data !== 8'd0) begin bad++; $display("FAIL basic_done: done=%b valid=%b busy=%b data=%0d want 1 0 1 0", done, out_valid, busy, out_data); end
        tick();
        total++; if (done !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL basic_idle: done=%b busy=%b want 0 0", done, busy); end
    endtask

    task automatic test_stall;
        int edges, beats, cyc;
        logic [7:0] prev_data;
        logic [3:0] prev_idx;
        logic hs;
        set_y_ramp(); out_ready = 1'b1;
        launch(edges);
        total++; if (edges !== 11) begin bad++; $display("FAIL stall_latency: got %0d want 11", edges); end
        beats = 0; cyc = 0;
        while (beats < 16 && cyc < 200) begin
            out_ready = ((cyc % 4) == 0) || ((cyc % 4) == 3);
            prev_data = out_data; prev_idx = out_idx;
            hs = out_valid && out_ready;
            if (hs) begin
                total++;
                if (out_idx !== 4'(beats) || out_data !== 8'(beats + 1)) begin
                    bad++; $display("FAIL stall_beat%0d: idx=%0d data=%0d want %0d/%0d", beats, out_idx, out_data, beats, beats + 1);
                end
                beats++;
            end
            tick(); cyc++;
            if (!hs && beats < 16) begin
                total++;
                if (out_valid !== 1'b1 || out_data !== prev_data || out_idx !== prev_idx) begin
                    bad++; $display("FAIL stall_hold: valid=%b data=%0d idx=%0d want 1/%0d/%0d", out_valid, out_data, out_idx, prev_data, prev_idx);
                end
            end
        end
        total++; if (beats !== 16) begin bad++; $display("FAIL stall_count: got %0d want 16", beats); end
        total++; if (done !== 1'b1) begin bad++; $display("FAIL stall_done: got %b want 1", done); end
        out_ready = 1'b1;
        tick();
    endtask

    task automatic test_snapshot;
        int edges;
        set_y_ramp(); out_ready = 1'b1;
        launch(edges);
        total++; if (edges !== 11) begin bad++; $display("FAIL snap_latency: got %0d want 11", edges); end
        for (int k = 0; k < 16; k++) y[k] = 8'hFF;
        for (int i = 0; i < 16; i++) begin
            total++;
            if (out_valid !== 1'b1 || out_data !== 8'(i + 1)) begin
                bad++; $display("FAIL snap_beat%0d: valid=%b data=%0d want 1/%0d", i, out_valid, out_data, i + 1);
            end
            tick();
        end
        total++; if (done !== 1'b1) begin bad++; $display("FAIL snap_done: got %b want 1", done); end
        tick();
        set_y_ramp();
    endtask

    task automatic test_start_ignored;
        int edges, ndone, nbusy;
        out_ready = 1'b1;
        start = 1'b1;
        tick();
        edges = 1;
        while (!out_valid && edges < 60) begin
            start = (edges == 4);
            tick();
            edges++;
        end
        start = 1'b0;
        total++; if (edges !== 11) begin bad++; $display("FAIL restart_wait_latency: got %0d want 11", edges); end
        for (int i = 0; i < 16; i++) begin
            start = (i == 7);
            total++;
            if (out_idx !== 4'(i) || out_data !== 8'(i + 1) || out_valid !== 1'b1) begin
                bad++; $display("FAIL restart_beat%0d: idx=%0d data=%0d valid=%b want %0d/%0d/1", i, out_idx, out_data, out_valid, i, i + 1);
            end
            tick();
        end
        total++; if (done !== 1'b1) begin bad++; $display("FAIL restart_done: got %b want 1", done); end
        start = 1'b1;
        tick();
        start = 1'b0;
        total++; if (busy !== 1'b0 || done !== 1'b0) begin bad++; $display("FAIL restart_done_start: busy=%b done=%b want 0 0", busy, done); end
        ndone = 0; nbusy = 0;
        for (int c = 0; c < 30; c++) begin
            tick();
            if (done) ndone++;
            if (busy) nbusy++;
        end
        total++; if (ndone !== 0 || nbusy !== 0) begin bad++; $display("FAIL restart_no_queue: done_cycles=%0d busy_cycles=%0d want 0 0", ndone, nbusy); end
    endtask

    task automatic test_reset_mid;
        int edges, ndone;
        set_y_ramp(); out_ready = 1'b1;
        launch(edges);
        total++; if (edges !== 11) begin bad++; $display("FAIL rmid_latency: got %0d want 11", edges); end
        repeat (6) tick();
        total++; if (out_idx !== 4'd6) begin bad++; $display("FAIL rmid_progress: idx=%0d want 6", out_idx); end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        total++; if (out_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || out_idx !== 4'd0 || out_data !== 8'd0) begin
            bad++; $display("FAIL rmid_reset: valid=%b busy=%b done=%b idx=%0d data=%0d want all 0", out_valid, busy, done, out_idx, out_data);
        end
        ndone = 0;
        for (int c = 0; c < 5; c++) begin
            tick();
            if (done || busy) ndone++;
        end
        total++; if (ndone !== 0) begin bad++; $display("FAIL rmid_no_done: active_cycles=%0d want 0", ndone); end
        launch(edges);
        total++; if (edges !== 11) begin bad++; $display("FAIL rmid_relatency: got %0d want 11", edges); end
        for (int i = 0; i < 16; i++) begin
            total++;
            if (out_idx !== 4'(i) || out_data !== 8'(i + 1) || out_valid !== 1'b1) begin
                bad++; $display("FAIL rmid_beat%0d: idx=%0d data=%0d valid=%b want %0d/%0d/1", i, out_idx, out_data, out_valid, i, i + 1);
            end
            tick();
        end
        total++; if (done !== 1'b1) begin bad++; $display("FAIL rmid_done: got %b want 1", done); end
        tick();
    endtask

    task automatic test_long_stall;
        int edges, nerr;
        set_y_ramp(); out_ready = 1'b1;
        launch(edges);
        total++; if (edges !== 11) begin bad++; $display("FAIL long_latency: got %0d want 11", edges); end
        repeat (15) tick();
        total++; if (out_idx !== 4'd15 || out_last !== 1'b1 || out_data !== 8'd16) begin bad++; $display("FAIL long_last: idx=%0d last=%b data=%0d want 15/1/16", out_idx, out_last, out_data); end
        out_ready = 1'b0;
        nerr = 0;
        for (int c = 0; c < 100; c++) begin
            tick();
            if (out_valid !== 1'b1 || out_last !== 1'b1 || out_data !== 8'd16 || out_idx !== 4'd15 || done !== 1'b0) nerr++;
        end
        total++; if (nerr !== 0) begin bad++; $display("FAIL long_hold: bad_cycles=%0d want 0", nerr); end
        out_ready = 1'b1;
        tick();
        total++; if (done !== 1'b1 || out_valid !== 1'b0 || out_last !== 1'b0) begin bad++; $display("FAIL long_done: done=%b valid=%b last=%b want 1 0 0", done, out_valid, out_last); end
        tick();
        total++; if (done !== 1'b0) begin bad++; $display("FAIL long_done_pulse: got %b want 0", done); end
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; out_ready = 1'b0;
        set_y_ramp();
        test_reset();
        test_basic();
        test_stall();
        test_snapshot();
        test_start_ignored();
        test_reset_mid();
        test_long_stall();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
